// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory responder: MMIO offsets, status bits, reset values.
package dmem_mmio_pkg;

   typedef enum logic [1:0] {
      OFF_CONSOLE_DATA   = 2'd0,
      OFF_CONSOLE_STATUS = 2'd1,
      OFF_CYCLE          = 2'd2,
      OFF_TIMER_CMP      = 2'd3
   } mmio_off_e;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVF   = 2;

   localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

   function automatic logic [31:0] status_word(input logic empty, input logic full, input logic ovf);
      logic [31:0] s;
      s = '0;
      s[ST_EMPTY] = empty;
      s[ST_FULL]  = full;
      s[ST_OVF]   = ovf;
      return s;
   endfunction

endpackage

// File: rtl/dmem_mmio_resp_byte_fifo.sv
// Console byte FIFO: occupancy-counted circular buffer, push accepted when full only if a pop coincides.
module byte_fifo #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic [7:0] din_i,
   input  logic       pop_i,
   output logic [7:0] head_o,
   output logic       full_o,
   output logic       empty_o
);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (PW+1)'(FIFO_DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && do_push)
         mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/dmem_mmio_resp.sv
// Data-bus responder: byte-enabled word RAM plus MMIO console FIFO and cycle counter.
// Optional TIMER_CMP register and irq are compiled in with DMEM_TIMER_CMP_EN.
module dmem_mmio_resp
   import dmem_mmio_pkg::*;
#(
   parameter int          DEPTH      = 1024,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FFF0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  we,
   output logic [31:0] drdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        irq
);
   localparam int AW = $clog2(DEPTH);

   logic          ram_hit, mmio_hit;
   mmio_off_e     off;
   logic [AW-1:0] widx;
   logic [31:0]   ram_rd, tcmp_rd;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic          ovf_q, ovf_d;
   logic [31:0]   cyc_q, cyc_d;

   assign ram_hit  = ((daddr >> (AW + 2)) == 32'd0);
   assign mmio_hit = (daddr[31:4] == MMIO_BASE[31:4]);
   assign off      = mmio_off_e'(daddr[3:2]);
   assign widx     = daddr[AW+1:2];

   // Each byte lane is its own array so a lane write never disturbs its neighbours.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH];
      always_ff @(posedge clk) begin
         if (rst && ram_hit && we[gi])
            mem_q[widx] <= dwdata[8*gi +: 8];
      end
      assign ram_rd[8*gi +: 8] = mem_q[widx];
   end

   assign fifo_push = mmio_hit && (off == OFF_CONSOLE_DATA) && we[0];
   assign fifo_pop  = tx_valid & tx_ready;
   assign tx_valid  = ~fifo_empty;

   byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .din_i   (dwdata[7:0]),
      .pop_i   (fifo_pop),
      .head_o  (tx_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      ovf_d = ovf_q;
      cyc_d = cyc_q + 32'd1;
      if (fifo_push && fifo_full && !fifo_pop)
         ovf_d = 1'b1;
      if (mmio_hit && (off == OFF_CONSOLE_STATUS) && we[0] && dwdata[ST_OVF])
         ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ovf_q <= 1'b0;
         cyc_q <= '0;
      end else begin
         ovf_q <= ovf_d;
         cyc_q <= cyc_d;
      end
   end

`ifdef DMEM_TIMER_CMP_EN
   logic [31:0] tcmp_q, tcmp_d;
   logic        irq_q;

   always_comb begin
      tcmp_d = tcmp_q;
      for (int i = 0; i < 4; i++)
         if (mmio_hit && (off == OFF_TIMER_CMP) && we[i])
            tcmp_d[8*i +: 8] = dwdata[8*i +: 8];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tcmp_q <= TIMER_CMP_RST;
         irq_q  <= 1'b0;
      end else begin
         tcmp_q <= tcmp_d;
         irq_q  <= (cyc_q >= tcmp_q);
      end
   end

   assign irq     = irq_q;
   assign tcmp_rd = tcmp_q;
`else
   assign irq     = 1'b0;
   assign tcmp_rd = '0;
`endif

   always_comb begin
      drdata = '0;
      if (ram_hit) begin
         drdata = ram_rd;
      end else if (mmio_hit) begin
         case (off)
            OFF_CONSOLE_STATUS: drdata = status_word(fifo_empty, fifo_full, ovf_q);
            OFF_CYCLE:          drdata = cyc_q;
            OFF_TIMER_CMP:      drdata = tcmp_rd;
            default:            drdata = '0;
         endcase
      end
   end

endmodule

// File: doc/dmem_mmio_resp.md
Name: dmem_mmio_resp

Overview:
- Data-side responder for the CPU_pipe data bus (daddr/dwdata/drdata/we); the memory end of the interface the core drives.
- Provides a byte-enabled word RAM and a small MMIO window at the top of the address space.
- The MMIO window holds:
  - a console byte FIFO, drained through a valid/ready output;
  - a free-running cycle counter.
- Drop-in replacement for the plain data memory in CPU test harnesses.

Parameters:
- DEPTH, 1024, RAM size in 32-bit words; power of 2.
- FIFO_DEPTH, 8, console FIFO entries; power of 2, ≥2.
- MMIO_BASE, 32'hFFFF_FFF0, base of the 16-byte MMIO window; 16-byte aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock, synchronous, active-low (rst=0 resets).
- daddr  in  32  byte address from CPU.
- dwdata  in  32  write data.
- we  in  4  byte-lane write enables; we[i] writes dwdata[8i+7:8i].
- drdata  out  32  read data, combinational from daddr.
- tx_data  out  8  console FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts head.
- irq  out  1  timer compare interrupt (0 unless DMEM_TIMER_CMP_EN).

Behaviour:
- Decode:
  - RAM hit when daddr < 4*DEPTH; word index is daddr[log2(DEPTH)+1:2]; daddr[1:0] ignored.
  - MMIO hit when daddr[31:4] == MMIO_BASE[31:4]; offset is daddr[3:2].
  - All other addresses: reads return 0, writes ignored.
- Reads: combinational, zero-latency. drdata reflects current storage, so a same-cycle write is not visible until the next cycle.
- Writes: on posedge clk when rst=1 and we≠0. Only enabled lanes are updated. Writes are ignored while rst=0.
- RAM contents are not cleared by reset.
- MMIO map, by offset:
  - 0x0 CONSOLE_DATA:
    - A write with we[0]=1 pushes dwdata[7:0].
    - Reads return 0.
  - 0x4 CONSOLE_STATUS:
    - Read layout: [0] empty, [1] full, [2] overflow (sticky), others 0.
    - A write with we[0]=1 and dwdata[2]=1 clears overflow.
  - 0x8 CYCLE:
    - Read-only 32-bit counter; 0 in the first cycle after reset release, +1 every cycle, wraps 0xFFFF_FFFF→0.
    - Writes are ignored.
  - 0xC TIMER_CMP: see Optional Feature; reads 0 when that feature is compiled out.
- Console FIFO:
  - Pop when tx_valid & tx_ready.
  - Push is accepted when not full, or when full with a pop in the same cycle (occupancy unchanged).
  - A push while full with no pop is dropped and sets overflow; FIFO contents are unchanged.
  - Push and pop in the same non-full cycle: occupancy unchanged, ordering preserved.
  - No bypass: a push into an empty FIFO raises tx_valid the next cycle.
  - tx_data is the head byte; it holds stable while tx_valid & ~tx_ready.
  - Pointers wrap modulo FIFO_DEPTH; full/empty come from an occupancy count of width log2(FIFO_DEPTH)+1.
- Reset values (rst=0 at posedge):
  - FIFO emptied; tx_valid=0; tx_data=0 when empty.
  - overflow=0, CYCLE=0, TIMER_CMP=32'hFFFF_FFFF, irq=0.
  - Reset mid-transfer discards all queued bytes.

Optional Feature:
- Macro: DMEM_TIMER_CMP_EN.
- Defined:
  - Offset 0xC is a R/W TIMER_CMP register with byte-lane writes.
  - irq is registered: irq <= (CYCLE >= TIMER_CMP), unsigned compare, so it appears one cycle after the condition holds.
  - irq stays high until TIMER_CMP is rewritten above CYCLE.
- Undefined:
  - 0xC reads 0 and writes are ignored.
  - irq is tied 0; no compare logic is synthesized.

Decomposition:
- Package dmem_mmio_pkg holds:
  - MMIO offset constants OFF_CONSOLE_DATA=2'd0, OFF_CONSOLE_STATUS=2'd1, OFF_CYCLE=2'd2, OFF_TIMER_CMP=2'd3;
  - status bit indices ST_EMPTY=0, ST_FULL=1, ST_OVF=2;
  - TIMER_CMP reset constant 32'hFFFF_FFFF.
- One sub-module, byte_fifo: parameterised by FIFO_DEPTH; push/pop/full/empty/head, synchronous active-low reset.
- RAM, decode and counters stay in the top module.

Test Plan:
- RAM byte lanes: write 0xAABBCCDD to 0x10 with we=4'hF, then 0x11223344 with we=4'b0010 → read of 0x10 returns 0xAABB33DD; same-cycle read during the write returns the old value.
- Console, stalled consumer: with tx_ready=0, write 0x41,0x42,0x43 to CONSOLE_DATA → tx_valid=1 the cycle after the first push, tx_data=0x41, STATUS=0. Raise tx_ready → bytes 0x41,0x42,0x43 on consecutive cycles, then STATUS reads 1 (empty).
- Console overflow: 9 pushes with tx_ready=0 → STATUS=0x6 and the 9th byte is lost. A write of 0x4 to STATUS gives 0x2; a push while full with tx_ready=1 in the same cycle is accepted.
- CYCLE counter: release rst, read CYCLE 10 cycles later → 10. Out-of-range: write to 0x8000_0000 has no effect and the read returns 0.
- Reset mid-operation: queue 4 bytes, pulse rst=0 for one cycle → tx_valid=0, STATUS=1, CYCLE restarts at 0, RAM still holds earlier data.
- DMEM_TIMER_CMP_EN: write TIMER_CMP=20 → irq rises exactly when CYCLE=21 (one cycle after CYCLE reaches 20). Writing 0xFFFF_FFFF clears irq on the next cycle. Without the macro, irq stays 0 and 0xC reads 0.
